// File: rtl/lcd_bus_writer.sv
// HD44780-style bus timing stage: takes one byte per valid/ready handshake and drives D/RS/RW/E.
// Optional power-on delay is built only when LCD_POWERUP_WAIT_EN is defined.
module lcd_bus_writer #(
    parameter int SETUP_CYC     = 4,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 2,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 82000,
    parameter int POWERUP_CYC   = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic [7:0] D,
    output logic       RS,
    output logic       RW,
    output logic       E
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || WAIT_CYC < 1 ||
        LONG_WAIT_CYC < 1 || POWERUP_CYC < 1) begin : g_bad_param
        $error("lcd_bus_writer: all cycle parameters must be >= 1");
    end

    localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
    localparam logic [31:0] PULSE_LD = 32'(PULSE_CYC - 1);
    localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] WAIT_LD  = 32'(WAIT_CYC - 1);
    localparam logic [31:0] LONG_LD  = 32'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  d_q, d_d;
    logic        rs_q, rs_d;
    logic        e_q, e_d;
    logic        ready_q, ready_d;

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_long(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rs_d    = rs_q;
        case (state_q)
            S_PWRUP: begin
`ifdef LCD_POWERUP_WAIT_EN
                // Counter starts at 0 out of reset, so power-up counts upward.
                if (cnt_q == 32'(POWERUP_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    d_d     = cmd_data;
                    rs_d    = cmd_rs;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long(rs_q, d_q) ? LONG_LD : WAIT_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase
        // E and ready are registered from the next state so they change cleanly on the edge.
        e_d     = (state_d == S_PULSE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            d_q     <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign D         = d_q;
    assign RS        = rs_q;
    assign E         = e_q;
    assign RW        = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomised and directed bench for lcd_bus_writer against a transaction-timing model.
// Expected power-up length follows LCD_POWERUP_WAIT_EN.
module tb_lcd_bus_writer;

    localparam int S  = 2;
    localparam int P  = 3;
    localparam int H  = 1;
    localparam int W  = 5;
    localparam int L  = 20;
    localparam int PU = 10;
`ifdef LCD_POWERUP_WAIT_EN
    localparam int PW = PU;
`else
    localparam int PW = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] D;
    logic       RS, RW, E;

    int checks = 0;
    int errors = 0;

    lcd_bus_writer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W),
        .LONG_WAIT_CYC(L), .POWERUP_CYC(PU)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .D(D), .RS(RS), .RW(RW), .E(E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle index since reset release, last accepted byte, and when ready returns.
    int         cyc = 0;
    int         rdy_at = PW;
    int         acc = 0;
    bit         have = 1'b0;
    logic       m_rs = 1'b0;
    logic [7:0] m_d = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc    <= 0;
            rdy_at <= PW;
            have   <= 1'b0;
            m_rs   <= 1'b0;
            m_d    <= 8'h00;
        end else begin
            if (cyc >= rdy_at && cmd_valid) begin
                acc    <= cyc;
                have   <= 1'b1;
                m_rs   <= cmd_rs;
                m_d    <= cmd_data;
                rdy_at <= cyc + 1 + S + P + H +
                          ((!cmd_rs && cmd_data[7:2] == 6'd0 && cmd_data[1:0] != 2'd0) ? L : W);
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic exp_rdy, exp_e;
        exp_rdy = !rst && (cyc >= rdy_at);
        exp_e   = !rst && have && (cyc >= acc + 1 + S) && (cyc <= acc + S + P);
        chk("cycle{rdy,E,RW,RS,D}", int'({cmd_ready, E, RW, RS, D}),
            int'({exp_rdy, exp_e, 1'b0, m_rs, m_d}));
    end

    // E pulse monitor for the streaming test.
    bit mon_en = 1'b0;
    int run = 0, pulses = 0, bad_w = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (E) run <= run + 1;
            else if (run > 0) begin
                pulses <= pulses + 1;
                if (run != P) bad_w <= bad_w + 1;
                run <= 0;
            end
        end
    end

    task automatic wait_ready(output int tr);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout_ready", 0, 1);
        tr = cyc;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int t);
        cmd_rs = rs;
        cmd_data = d;
        cmd_valid = 1'b1;
        wait_ready(t);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic xfer(input string name, input logic rs, input logic [7:0] d,
                        input int exp_ret, input bit poke);
        int t, tr, ef, el, n;
        send(rs, d, t);
        chk({name, "_busD"}, int'({RS, D}), int'({rs, d}));
        ef = -1; el = -1; n = 0;
        while (!cmd_ready && n < 200) begin
            if (E) begin
                if (ef < 0) ef = cyc;
                el = cyc;
                if (poke) cmd_data = 8'hFF;
            end
            @(negedge clk);
            n++;
        end
        tr = cyc;
        chk({name, "_e_first"}, ef - t, 3);
        chk({name, "_e_last"}, el - t, 5);
        chk({name, "_ready_ret"}, tr - t, exp_ret);
        if (poke) chk({name, "_d_kept"}, int'(D), int'(d));
    endtask

    initial begin
        int t, tr, n;
        int acc_t[4];
        logic [7:0] strm[4];
        strm[0] = 8'h38; strm[1] = 8'h0F; strm[2] = 8'h01; strm[3] = 8'h80;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({cmd_ready, E, RW, RS, D}), 0);

        // Valid is presented during power-up; it must not be taken early.
        cmd_rs = 1'b1; cmd_data = 8'h55; cmd_valid = 1'b1;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        chk("pwrup_edges", n, PW);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("first_accept_D", int'(D), 8'h55);
        wait_ready(tr);

        xfer("char4A", 1'b1, 8'h4A, 12, 1'b0);
        xfer("clear", 1'b0, 8'h01, 27, 1'b0);
        xfer("func38", 1'b0, 8'h38, 12, 1'b0);
        xfer("rs1_01", 1'b1, 8'h01, 12, 1'b0);
        xfer("cmd00", 1'b0, 8'h00, 12, 1'b0);
        xfer("home03", 1'b0, 8'h03, 27, 1'b0);
        xfer("home02_poke", 1'b0, 8'h02, 27, 1'b1);

        // Valid raised during WAIT must wait for ready.
        send(1'b0, 8'h38, t);
        while (cyc < t + 8) @(negedge clk);
        cmd_rs = 1'b0; cmd_data = 8'hC0; cmd_valid = 1'b1;
        wait_ready(tr);
        chk("busy_valid_ret", tr - t, 12);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_valid_D", int'(D), 8'hC0);
        wait_ready(tr);

        // Back-to-back streaming.
        mon_en = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_rs = 1'b0;
            cmd_data = strm[i];
            wait_ready(acc_t[i]);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_ready(tr);
        @(negedge clk);
        mon_en = 1'b0;
        chk("stream_gap1", acc_t[1] - acc_t[0], 12);
        chk("stream_gap2", acc_t[2] - acc_t[1], 12);
        chk("stream_gap3", acc_t[3] - acc_t[2], 27);
        chk("stream_pulses", pulses, 4);
        chk("stream_bad_width", bad_w, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!cmd_valid || ($urandom % 8) == 0) begin
                cmd_valid = ($urandom % 3) != 0;
                cmd_rs = $urandom % 2;
                cmd_data = (($urandom % 3) == 0) ? 8'($urandom % 4) : 8'($urandom);
            end
        end
        cmd_valid = 1'b0;
        wait_ready(tr);

        // Asynchronous reset while E is high.
        cmd_rs = 1'b1; cmd_data = 8'h41; cmd_valid = 1'b1;
        n = 0;
        while (!E && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("reset_saw_E", int'(E), 1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", int'({cmd_ready, E, RW, RS, D}), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        chk("pwrup_edges_2", n, PW);
        xfer("after_reset", 1'b1, 8'h4A, 12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
